reg_file_sync: RTL and testbench

- Integer register file written by the write-back stage and read by the decode stage.
- One write port, driven directly by the write-back stage's rf_we, wreg and wdata outputs.
- Two synchronous read ports with 1-cycle latency, suited to FPGA block RAM.
- Block RAM has no reset, so a post-reset clear state machine zeroes every entry before rf_ready asserts.

---
 rtl/reg_file_sync_if.sv | 26 ++
 rtl/reg_file_sync.sv | 120 ++++++++++++
 tb/tb_reg_file_sync.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/reg_file_sync_if.sv
// Register-file bus: one write port from write-back, two read ports to decode.
// master = pipeline side (drives write/read requests), slave = register file.
interface reg_file_sync_if #(
    parameter int DW  = 32,
    parameter int RFW = 5
);
    logic           rf_we;
    logic [RFW-1:0] wreg;
    logic [DW-1:0]  wdata;
    logic           rd_en;
    logic [RFW-1:0] raddr1;
    logic [RFW-1:0] raddr2;
    logic [DW-1:0]  rdata1;
    logic [DW-1:0]  rdata2;
    logic           rf_ready;

    modport master (
        output rf_we, wreg, wdata, rd_en, raddr1, raddr2,
        input  rdata1, rdata2, rf_ready
    );

    modport slave (
        input  rf_we, wreg, wdata, rd_en, raddr1, raddr2,
        output rdata1, rdata2, rf_ready
    );
endinterface

// File: rtl/reg_file_sync.sv
// Integer register file: one write port, two registered read ports (1-cycle
// latency, block-RAM friendly). The RAM has no reset, so after rst a sweep
// zeroes every entry before rf_ready rises.
//
// Build option: define RF_WR_BYPASS_EN to make a same-cycle write to a
// register being read appear on the read port (write-through). Without it the
// read returns the value held before the write (read-old).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zeroing mem[clr_ptr] each cycle; port inputs ignored
// ST_RUN   | normal operation; rf_ready=1, left only through rst
module reg_file_sync #(
    parameter int DW  = 32,
    parameter int RFW = 5
) (
    input  logic            clk,
    input  logic            rst,
    reg_file_sync_if.slave  bus
);
    localparam int DEPTH = 1 << RFW;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t         state;
    logic [RFW-1:0] clr_ptr;
    logic [DW-1:0]  mem [DEPTH];

    logic           mem_we;
    logic [RFW-1:0] mem_waddr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  rd_val1;
    logic [DW-1:0]  rd_val2;

    logic [DW-1:0]  rdata1_q;
    logic [DW-1:0]  rdata2_q;
    logic           rf_ready_q;

    assign bus.rdata1   = rdata1_q;
    assign bus.rdata2   = rdata2_q;
    assign bus.rf_ready = rf_ready_q;

    // Single RAM write port shared by the clear sweep and the write-back stage.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (!rst) begin
            case (state)
                ST_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = clr_ptr;
                    mem_wdata = '0;
                end
                ST_RUN: begin
                    mem_we    = bus.rf_we && (bus.wreg != '0);
                    mem_waddr = bus.wreg;
                    mem_wdata = bus.wdata;
                end
                default: ;
            endcase
        end
    end

    // RAM array, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Next read data: index 0 is hard-wired to zero; optional write-through.
    always_comb begin
        rd_val1 = (bus.raddr1 == '0) ? '0 : mem[bus.raddr1];
        rd_val2 = (bus.raddr2 == '0) ? '0 : mem[bus.raddr2];
`ifdef RF_WR_BYPASS_EN
        if (bus.rf_we && (bus.wreg != '0) && (bus.wreg == bus.raddr1))
            rd_val1 = bus.wdata;
        if (bus.rf_we && (bus.wreg != '0) && (bus.wreg == bus.raddr2))
            rd_val2 = bus.wdata;
`endif
    end

    // Control FSM with registered read data and ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clr_ptr    <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            rf_ready_q <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_ptr  <= clr_ptr + RFW'(1);
                    rdata1_q <= '0;
                    rdata2_q <= '0;
                    if (clr_ptr == {RFW{1'b1}}) begin
                        state      <= ST_RUN;
                        rf_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    rf_ready_q <= 1'b1;
                    if (bus.rd_en) begin
                        rdata1_q <= rd_val1;
                        rdata2_q <= rd_val2;
                    end
                end
                default: begin
                    state      <= ST_CLEAR;
                    clr_ptr    <= '0;
                    rf_ready_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_sync.sv
// Directed bench for reg_file_sync: clear sweep timing, table of RUN-mode
// read/write vectors, and reset during RUN and during the sweep.
module tb_reg_file_sync;
    localparam int DW  = 32;
    localparam int RFW = 5;
`ifdef RF_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    reg_file_sync_if #(.DW(DW), .RFW(RFW)) rf_bus ();

    reg_file_sync #(.DW(DW), .RFW(RFW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        rd_en;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic re, input logic [4:0] a1, input logic [4:0] a2);
        rf_bus.rf_we  = we;
        rf_bus.wreg   = wr;
        rf_bus.wdata  = wd;
        rf_bus.rd_en  = re;
        rf_bus.raddr1 = a1;
        rf_bus.raddr2 = a2;
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i));
            tick();
            check({name, "_p1"}, rf_bus.rdata1, 32'h0);
            check({name, "_p2"}, rf_bus.rdata2, 32'h0);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd0,  5'd0,  32'h0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  32'h0, 32'h0};
        vecs[4]  = '{1'b1, 5'd7,  32'h11111111, 1'b1, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
        vecs[5]  = '{1'b1, 5'd7,  32'h22222222, 1'b1, 5'd0,  5'd7,  32'h0,
                     BYP ? 32'h22222222 : 32'h11111111};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  32'h22222222, 32'h22222222};
        vecs[7]  = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b1, 5'd7,  5'd5,  32'h22222222, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd0,  32'hA5A5A5A5, 32'h0};
        vecs[9]  = '{1'b1, 5'd3,  32'h5A5A5A5A, 1'b0, 5'd4,  5'd7,  32'hA5A5A5A5, 32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd4,  5'd3,  32'hA5A5A5A5, 32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd4,  32'h5A5A5A5A, 32'h0};
        vecs[12] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 5'd31,
                     BYP ? 32'hCAFEF00D : 32'h0, BYP ? 32'hCAFEF00D : 32'h0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd3,  32'hCAFEF00D, 32'h5A5A5A5A};
        vecs[14] = '{1'b1, 5'd9,  32'h12345678, 1'b1, 5'd0,  5'd0,  32'h0, 32'h0};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd5,  32'h12345678, 32'hDEADBEEF};
        vecs[16] = '{1'b1, 5'd5,  32'h0BADF00D, 1'b0, 5'd5,  5'd5,  32'h12345678, 32'hDEADBEEF};
        vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd9,  32'h0BADF00D, 32'h12345678};

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        // Power-up reset, then the 32-edge clear sweep.
        rst = 1'b1;
        tick();
        tick();
        check("reset_ready", {31'b0, rf_bus.rf_ready}, 32'h0);
        check("reset_rdata1", rf_bus.rdata1, 32'h0);
        check("reset_rdata2", rf_bus.rdata2, 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            check($sformatf("sweep_ready_e%0d", i), {31'b0, rf_bus.rf_ready},
                  (i == 32) ? 32'h1 : 32'h0);
        end
        read_all_zero("post_clear");

        // Table-driven RUN vectors.
        foreach (vecs[k]) begin
            drive(vecs[k].we, vecs[k].wreg, vecs[k].wdata, vecs[k].rd_en, vecs[k].ra1, vecs[k].ra2);
            tick();
            check($sformatf("vec%0d_rdata1", k), rf_bus.rdata1, vecs[k].exp1);
            check($sformatf("vec%0d_rdata2", k), rf_bus.rdata2, vecs[k].exp2);
            check($sformatf("vec%0d_ready", k), {31'b0, rf_bus.rf_ready}, 32'h1);
        end

        // Fill every register, then reset mid-RUN and again mid-sweep.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'hC0DE0000 | 32'(i), 1'b0, 5'd0, 5'd0);
            tick();
        end
        drive(1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd20);
        tick();
        check("prefill_r9", rf_bus.rdata1, 32'h12345678);
        check("prefill_r20", rf_bus.rdata2, 32'hC0DE0014);

        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9);
        tick();
        check("midrun_rst_ready", {31'b0, rf_bus.rf_ready}, 32'h0);
        check("midrun_rst_rdata1", rf_bus.rdata1, 32'h0);
        rst = 1'b0;
        drive(1'b1, 5'd9, 32'hFFFFFFFF, 1'b1, 5'd9, 5'd9);
        for (int i = 0; i < 10; i++)
            tick();
        check("midclear_ready", {31'b0, rf_bus.rf_ready}, 32'h0);
        check("midclear_rdata1", rf_bus.rdata1, 32'h0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 5'd20, 32'hFFFFFFFF, 1'b1, 5'd20, 5'd9);
        for (int i = 1; i <= 32; i++) begin
            tick();
            check($sformatf("resweep_ready_e%0d", i), {31'b0, rf_bus.rf_ready},
                  (i == 32) ? 32'h1 : 32'h0);
            check($sformatf("resweep_rdata1_e%0d", i), rf_bus.rdata1, 32'h0);
        end
        read_all_zero("post_reclear");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
